// File: rtl/pll_sup_pkg.sv
// Shared types and default constants for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [1:0] {
        S_PLL_RST   = 2'b00,
        S_WAIT_LOCK = 2'b01,
        S_STABLE    = 2'b10,
        S_RUN       = 2'b11
    } state_t;

    localparam int DEF_PLL_RST_CYCLES      = 16;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 500000;   // 10 ms at 50 MHz
    localparam int DEF_STABLE_CYCLES       = 65536;
    localparam int DEF_SYNC_STAGES         = 2;
    localparam int DEF_CNT_W               = 8;

    // Largest of three cycle limits; sizes the shared state timer.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Plain flop-chain synchroniser for a single asynchronous bit.
module cdc_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through STAGES flops.
    always_ff @(posedge clk) begin
        if (rst) chain <= '0;
        else     chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset / lock qualification controller running on the PLL reference clock.
// Optional macro PLL_WATCHDOG_EN: retries the PLL reset when lock never arrives.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int STABLE_CYCLES       = DEF_STABLE_CYCLES,
    parameter int SYNC_STAGES         = DEF_SYNC_STAGES,
    parameter int CNT_W               = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             locked_in,
    input  logic             force_relock,
    input  logic             clear_stats,
    output logic             pll_rst,
    output logic             sys_reset_req,
    output logic             ready,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] loss_count,
    output logic [CNT_W-1:0] retry_count
);

    localparam int TMR_MAX = max3(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES);
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(PLL_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] STABLE_LAST = TMR_W'(STABLE_CYCLES - 1);
`ifdef PLL_WATCHDOG_EN
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);
`endif

    state_t           state;
    state_t           state_next;
    logic [TMR_W-1:0] timer;
    logic             locked_s;
    logic             loss_inc;
`ifdef PLL_WATCHDOG_EN
    logic             retry_inc;
`endif

    cdc_sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_locked_sync (
        .clk(clk),
        .rst(rst),
        .d  (locked_in),
        .q  (locked_s)
    );

    // Next-state decode and counter increment requests.
    always_comb begin
        state_next = state;
        loss_inc   = 1'b0;
`ifdef PLL_WATCHDOG_EN
        retry_inc  = 1'b0;
`endif
        case (state)
            S_PLL_RST: begin
                if (timer == RST_LAST) state_next = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    state_next = S_STABLE;
                end
`ifdef PLL_WATCHDOG_EN
                else if (timer == TIMEOUT_LAST) begin
                    state_next = S_PLL_RST;
                    retry_inc  = 1'b1;
                end
`endif
            end
            S_STABLE: begin
                if (!locked_s)                 state_next = S_WAIT_LOCK;
                else if (timer == STABLE_LAST) state_next = S_RUN;
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_next = S_PLL_RST;
                    loss_inc   = 1'b1;
                end
            end
            default: state_next = S_PLL_RST;
        endcase
        // A relock request overrides everything, but never restarts an ongoing PLL reset.
        if (force_relock && (state != S_PLL_RST)) state_next = S_PLL_RST;
    end

    // State register, shared timer and registered Moore outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_PLL_RST;
            timer         <= '0;
            pll_rst       <= 1'b1;
            sys_reset_req <= 1'b1;
            ready         <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state) timer <= '0;
            else if (timer != '1)    timer <= timer + 1'b1;
            // Decoding the next state keeps the outputs glitch-free and cycle-aligned with state.
            pll_rst       <= (state_next == S_PLL_RST);
            sys_reset_req <= (state_next != S_RUN);
            ready         <= (state_next == S_RUN);
        end
    end

    // Saturating lock-loss counter; clear has priority over an increment.
    always_ff @(posedge clk) begin
        if (rst)                                 loss_count <= '0;
        else if (clear_stats)                    loss_count <= '0;
        else if (loss_inc && (loss_count != '1)) loss_count <= loss_count + CNT_W'(1);
    end

`ifdef PLL_WATCHDOG_EN
    // Saturating watchdog retry counter; clear has priority over an increment.
    always_ff @(posedge clk) begin
        if (rst)                                   retry_count <= '0;
        else if (clear_stats)                      retry_count <= '0;
        else if (retry_inc && (retry_count != '1)) retry_count <= retry_count + CNT_W'(1);
    end
`else
    assign retry_count = '0;
`endif

    assign state_o = state;

endmodule
